arbiter_wrr: RTL and testbench



---
 rtl/arbiter_pkg.sv | 23 ++
 rtl/arbiter_rr_pick.sv | 33 +++
 rtl/arbiter_wrr.sv | 79 +++++++
 tb/tb_arbiter_wrr.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared helpers for the arbiter family: index-width guard, one-hot decode and
// saturating decrement.
package arbiter_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Returns the index of the lowest set bit; 0 when nothing is set.
  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int sat_dec(input int x);
    return (x > 0) ? x - 1 : 0;
  endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Rotating-priority search: first set bit of req scanning start+1, start+2, ...
// wrapping around so that start itself has the lowest priority.
module arbiter_rr_pick
  import arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] winner,
  output logic          found
);

  int idx;

  // NOTE: every output and temporary gets a default before the loop, so no
  // path through the block leaves a value held and no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    // Walk from the lowest priority to the highest so the last hit wins.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(start) + k) % N;
      if (req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with per-requester burst credits, owner lock and
// a ready handshake; the grant is combinational from req and registered ownership.
module arbiter_wrr
  import arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock_req,
  input  logic [N*WW-1:0] weight,
  input  logic            enable,
  input  logic            ready,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_valid
);

  logic [IW-1:0] p;
  logic          own;
  logic [WW-1:0] cred;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] winner;
  logic          held;
  logic          fire;
  logic [WW-1:0] w_raw;
  logic [WW-1:0] w_win;
  logic [WW-1:0] cred_dec;

  arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .start  (p),
    .winner (pick_idx),
    .found  (pick_found)
  );

  assign held      = own && req[p];
  assign winner    = held ? p : pick_idx;
  assign gnt_valid = enable && pick_found;
  assign gnt       = gnt_valid ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;
  assign gnt_id    = IW'(onehot_to_idx(32'(gnt)));
  assign fire      = gnt_valid && ready;

  // A zero weight still buys one beat so a requester can never be starved.
  assign w_raw    = weight[int'(winner)*WW +: WW];
  assign w_win    = (w_raw == '0) ? WW'(1) : w_raw;
  assign cred_dec = WW'(sat_dec(int'(cred)));

  // NOTE: state registers use non-blocking assignments so every branch reads
  // the pre-edge values of p, own and cred.
  always_ff @(posedge clk) begin
    if (rst) begin
      p    <= IW'(N - 1);
      own  <= 1'b0;
      cred <= '0;
    end else if (gnt_valid && !held) begin
      p <= winner;
      if (fire) begin
        cred <= w_win - WW'(1);
        own  <= lock_req[winner] || (w_win != WW'(1));
      end else begin
        cred <= w_win;
        own  <= 1'b1;
      end
    end else if (held && fire) begin
      cred <= cred_dec;
      own  <= lock_req[p] || (cred_dec != '0);
    end else if (own && !req[p]) begin
      // Owner left and nobody new was granted this cycle.
      own <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbiter_wrr.sv
// Scenario bench for arbiter_wrr: expected grants are queued as stimulus is
// applied and popped against the DUT outputs at the falling edge.
module tb_arbiter_wrr;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    lock_req;
  logic [N*WW-1:0] weight;
  logic            enable;
  logic            ready;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_id;
  logic            gnt_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string          name;
    logic [N-1:0]   gnt;
  } exp_t;

  exp_t sb[$];

  arbiter_wrr #(.N(N), .WW(WW), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock_req  (lock_req),
    .weight    (weight),
    .enable    (enable),
    .ready     (ready),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // Expected {gnt_valid, gnt_id, gnt} derived from an expected one-hot grant.
  function automatic logic [N+IW:0] exp_vec(input logic [N-1:0] g);
    logic [IW-1:0] id;
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) id = IW'(i);
    end
    return {|g, id, g};
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    lock_req = '0;
    weight   = {N{4'd1}};
    enable   = 1'b1;
    ready    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; req = '0; lock_req = '0; weight = {N{4'd1}};
    enable = 1'b1; ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst = 1'b0;
      sb.push_back('{$sformatf("reset_idle[%0d]", c), 4'b0000});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt_valid, gnt_id, gnt} !== exp_vec(e.gnt)) begin
        failures++;
        $display("FAIL %s: got v=%b id=%0d gnt=%b, want gnt=%b", e.name, gnt_valid, gnt_id, gnt, e.gnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_equal_weights();
    logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_t e;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      sb.push_back('{$sformatf("equal_w[%0d]", c), seq[c]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt_valid, gnt_id, gnt} !== exp_vec(e.gnt)) begin
        failures++;
        $display("FAIL %s: got v=%b id=%0d gnt=%b, want gnt=%b", e.name, gnt_valid, gnt_id, gnt, e.gnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_weighted();
    int ids [9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    exp_t e;
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    req    = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      sb.push_back('{$sformatf("weighted[%0d]", c), 4'b0001 << ids[c]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt_valid, gnt_id, gnt} !== exp_vec(e.gnt)) begin
        failures++;
        $display("FAIL %s: got v=%b id=%0d gnt=%b, want gnt=%b", e.name, gnt_valid, gnt_id, gnt, e.gnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    // Weight 2 on requester 0: claim under stall, then two accepted beats.
    logic         rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [N-1:0] seq [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    exp_t e;
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd2};
    req    = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      ready = rdy[c];
      sb.push_back('{$sformatf("backpressure[%0d]", c), seq[c]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt_valid, gnt_id, gnt} !== exp_vec(e.gnt)) begin
        failures++;
        $display("FAIL %s: got v=%b id=%0d gnt=%b, want gnt=%b", e.name, gnt_valid, gnt_id, gnt, e.gnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    logic [N-1:0] seq [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                              4'b0010, 4'b0100, 4'b0010};
    exp_t e;
    do_reset();
    req      = 4'b0110;
    lock_req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) lock_req = 4'b0000;
      sb.push_back('{$sformatf("lock[%0d]", c), seq[c]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt_valid, gnt_id, gnt} !== exp_vec(e.gnt)) begin
        failures++;
        $display("FAIL %s: got v=%b id=%0d gnt=%b, want gnt=%b", e.name, gnt_valid, gnt_id, gnt, e.gnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_owner_drop();
    // Requester 3 has weight 0, which must behave as a single beat per turn.
    logic [N-1:0] rq  [4] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000};
    exp_t e;
    do_reset();
    weight = {4'd0, 4'd4, 4'd1, 4'd1};
    for (int c = 0; c < 4; c++) begin
      req = rq[c];
      sb.push_back('{$sformatf("owner_drop[%0d]", c), rq[c]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt_valid, gnt_id, gnt} !== exp_vec(e.gnt)) begin
        failures++;
        $display("FAIL %s: got v=%b id=%0d gnt=%b, want gnt=%b", e.name, gnt_valid, gnt_id, gnt, e.gnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_enable();
    // Two beats of a 4-beat burst, reset mid-burst, then a fresh 4-beat burst
    // split by two cycles with enable low.
    logic         rs  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         en  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] seq [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
    exp_t e;
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd4};
    req    = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      rst    = (c < 9) ? rs[c] : 1'b0;
      enable = (c < 9) ? en[c] : 1'b1;
      sb.push_back('{$sformatf("reset_enable[%0d]", c), seq[c]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({gnt_valid, gnt_id, gnt} !== exp_vec(e.gnt)) begin
        failures++;
        $display("FAIL %s: got v=%b id=%0d gnt=%b, want gnt=%b", e.name, gnt_valid, gnt_id, gnt, e.gnt);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal_weights();
    test_weighted();
    test_backpressure();
    test_lock();
    test_owner_drop();
    test_reset_enable();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
